// File: rtl/sram_mem_controller.sv
// sram_mem_controller
// Data-memory responder for the MEM stage. Each 32-bit pipeline word is stored as two
// 16-bit half-words on an external asynchronous SRAM (low half at even half-word address,
// high half at odd). ready drops while an access is in flight so the pipeline freezes.
//
// Ports:
//   clk, rst                 clock (rising edge), synchronous active-high reset
//   wr_en, rd_en             store / load request, held stable while ready=0
//   address, write_data      byte address (ALU result) and store data
//   read_data                registered load result
//   ready                    1 = no access pending or access completing this cycle
//   sram_addr                half-word address
//   sram_dq_out, sram_dq_in  SRAM write / read data
//   sram_dq_oe               1 = controller drives DQ
//   sram_we_n, sram_oe_n     active-low write / output enables
//   sram_ce_n/ub_n/lb_n      tied low (chip always selected, both bytes)
module sram_mem_controller #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned SRAM_DW   = 16,
    parameter int unsigned SRAM_AW   = 18,
    parameter int unsigned ADDR_BASE = 1024,
    parameter int unsigned WAIT_CYC  = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               wr_en,
    input  logic               rd_en,
    input  logic [31:0]        address,
    input  logic [DATA_W-1:0]  write_data,
    output logic [DATA_W-1:0]  read_data,
    output logic               ready,
    output logic [SRAM_AW-1:0] sram_addr,
    output logic [SRAM_DW-1:0] sram_dq_out,
    input  logic [SRAM_DW-1:0] sram_dq_in,
    output logic               sram_dq_oe,
    output logic               sram_we_n,
    output logic               sram_oe_n,
    output logic               sram_ce_n,
    output logic               sram_ub_n,
    output logic               sram_lb_n
);

    typedef enum logic [2:0] {StIdle, StWrLo, StWrHi, StRdLo, StRdHi, StDone} state_e;

    localparam int unsigned CntW = (WAIT_CYC > 0) ? $clog2(WAIT_CYC + 1) : 1;

    state_e              state_q, state_d;
    logic [CntW-1:0]     wait_q, wait_d;
    logic [DATA_W-1:0]   read_data_q;
    logic                last_cyc;
    logic [31:0]         offset;
    logic [SRAM_AW-2:0]  word;
    logic                unused_offset;

    // Word index relative to the base, wrapped to the SRAM size.
    assign offset        = address - 32'(ADDR_BASE);
    assign word          = offset[SRAM_AW:2];
    assign unused_offset = ^{offset[31:SRAM_AW+1], offset[1:0]};

    // Each half-word access lasts WAIT_CYC+1 cycles; the final one is the hold cycle.
    assign last_cyc = (wait_q == CntW'(WAIT_CYC));

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    // Next-state logic; the wait counter clears whenever a state is (re)entered.
    always_comb begin
        state_d = state_q;
        wait_d  = '0;
        unique case (state_q)
            StIdle: begin
                if (wr_en)      state_d = StWrLo;
                else if (rd_en) state_d = StRdLo;
            end
            StWrLo: begin
                if (last_cyc) state_d = StWrHi;
                else          wait_d  = wait_q + CntW'(1);
            end
            StWrHi: begin
                if (last_cyc) state_d = StDone;
                else          wait_d  = wait_q + CntW'(1);
            end
            StRdLo: begin
                if (last_cyc) state_d = StRdHi;
                else          wait_d  = wait_q + CntW'(1);
            end
            StRdHi: begin
                if (last_cyc) state_d = StDone;
                else          wait_d  = wait_q + CntW'(1);
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Output logic
    always_comb begin
        ready       = 1'b0;
        sram_addr   = '0;
        sram_dq_out = '0;
        sram_dq_oe  = 1'b0;
        sram_we_n   = 1'b1;
        sram_oe_n   = 1'b1;
        unique case (state_q)
            StIdle: ready = ~(wr_en | rd_en);
            StWrLo: begin
                sram_addr   = {word, 1'b0};
                sram_dq_out = write_data[SRAM_DW-1:0];
                sram_dq_oe  = 1'b1;
                // WE rises for the last cycle so addr/data hold across its rising edge
                sram_we_n   = last_cyc;
            end
            StWrHi: begin
                sram_addr   = {word, 1'b1};
                sram_dq_out = write_data[DATA_W-1:SRAM_DW];
                sram_dq_oe  = 1'b1;
                sram_we_n   = last_cyc;
            end
            StRdLo: begin
                sram_addr = {word, 1'b0};
                sram_oe_n = 1'b0;
            end
            StRdHi: begin
                sram_addr = {word, 1'b1};
                sram_oe_n = 1'b0;
            end
            StDone:  ready = 1'b1;
            default: ready = 1'b0;
        endcase
    end

    // Read capture: each half is sampled in the last cycle of its access.
    always_ff @(posedge clk) begin
        if (rst) begin
            read_data_q <= '0;
        end else if (last_cyc && state_q == StRdLo) begin
            read_data_q[SRAM_DW-1:0] <= sram_dq_in;
        end else if (last_cyc && state_q == StRdHi) begin
            read_data_q[DATA_W-1:SRAM_DW] <= sram_dq_in;
        end
    end

    assign read_data = read_data_q;
    assign sram_ce_n = 1'b0;
    assign sram_ub_n = 1'b0;
    assign sram_lb_n = 1'b0;

endmodule
